// File: rtl/gpio_event_detect.sv
// Per-pin GPIO event front-end: 2-flop sync, optional debounce (GPIO_DEBOUNCE_EN), edge/level detect, sticky pending, aggregated irq.
// Latency in->gpio_sync_o 3 edges (+deb_thresh_i when filtered); pending/irq one edge later. No backpressure.
module gpio_event_detect #(
  parameter int NUM_GPIO      = 32,
  parameter int DEB_CNT_WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NUM_GPIO-1:0]      gpio_in_i,
  input  logic [NUM_GPIO-1:0]      gpio_en_i,
  input  logic [2*NUM_GPIO-1:0]    irq_type_i,
  input  logic [DEB_CNT_WIDTH-1:0] deb_thresh_i,
  input  logic [NUM_GPIO-1:0]      clr_i,
  output logic [NUM_GPIO-1:0]      gpio_sync_o,
  output logic [NUM_GPIO-1:0]      pending_o,
  output logic                     irq_o
);

  logic [NUM_GPIO-1:0] r_sync1;
  logic [NUM_GPIO-1:0] r_sync2;
  logic [NUM_GPIO-1:0] r_stable;
  logic [NUM_GPIO-1:0] r_stable_q;
  logic [NUM_GPIO-1:0] r_pending;
  logic                r_irq;
  logic [NUM_GPIO-1:0] w_rise;
  logic [NUM_GPIO-1:0] w_fall;
  logic [NUM_GPIO-1:0] w_event;
  logic [NUM_GPIO-1:0] w_pending_nxt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= gpio_in_i;
      r_sync2 <= r_sync1;
    end
  end

`ifdef GPIO_DEBOUNCE_EN
  logic [DEB_CNT_WIDTH-1:0] r_cnt [NUM_GPIO];

  // A new level is accepted on the (thresh+1)th consecutive mismatching cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_stable <= '0;
      for (int i = 0; i < NUM_GPIO; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_GPIO; i++) begin
        if (r_sync2[i] == r_stable[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == deb_thresh_i) begin
          r_stable[i] <= r_sync2[i];
          r_cnt[i]    <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + DEB_CNT_WIDTH'(1);
        end
      end
    end
  end
`else
  logic w_unused_thresh;
  assign w_unused_thresh = ^deb_thresh_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_stable <= '0;
    else         r_stable <= r_sync2;
  end
`endif

  // Edge history runs regardless of enable so enabling never fakes an edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_stable_q <= '0;
    else         r_stable_q <= r_stable;
  end

  assign w_rise = r_stable & ~r_stable_q;
  assign w_fall = ~r_stable & r_stable_q;

  always_comb begin
    w_event = '0;
    for (int i = 0; i < NUM_GPIO; i++) begin
      unique case (irq_type_i[2*i +: 2])
        2'b00:   w_event[i] = w_fall[i];
        2'b01:   w_event[i] = w_rise[i];
        2'b10:   w_event[i] = w_rise[i] | w_fall[i];
        default: w_event[i] = r_stable[i];
      endcase
    end
  end

  // Set beats clear when both land in the same cycle.
  assign w_pending_nxt = (r_pending & ~clr_i) | (w_event & gpio_en_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_pending <= '0;
      r_irq     <= 1'b0;
    end else begin
      r_pending <= w_pending_nxt;
      r_irq     <= |w_pending_nxt;
    end
  end

  assign gpio_sync_o = r_stable;
  assign pending_o   = r_pending;
  assign irq_o       = r_irq;

endmodule

// File: tb/tb_gpio_event_detect.sv
// Bench for gpio_event_detect: vector table, directed corner sequences, and randomized run against a history-based model.
module tb_gpio_event_detect;

`ifdef GPIO_DEBOUNCE_EN
  localparam bit DEB = 1'b1;
`else
  localparam bit DEB = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [31:0] gpio_in_i;
  logic [31:0] gpio_en_i;
  logic [63:0] irq_type_i;
  logic [7:0]  deb_thresh_i;
  logic [31:0] clr_i;
  logic [31:0] gpio_sync_o;
  logic [31:0] pending_o;
  logic        irq_o;

  gpio_event_detect #(.NUM_GPIO(32), .DEB_CNT_WIDTH(8)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .gpio_in_i    (gpio_in_i),
    .gpio_en_i    (gpio_en_i),
    .irq_type_i   (irq_type_i),
    .deb_thresh_i (deb_thresh_i),
    .clr_i        (clr_i),
    .gpio_sync_o  (gpio_sync_o),
    .pending_o    (pending_o),
    .irq_o        (irq_o)
  );

  always #5 clk_i = ~clk_i;

  int n_pass = 0;
  int n_total = 0;

  // Model: raw input history (newest first) plus the filtered level and pending flags.
  logic [31:0] samp[$];
  logic [31:0] m_stable, m_stable_q, m_pending;
  logic [31:0] cin;

  typedef struct {
    logic [31:0] in;
    logic [31:0] clr;
    logic [31:0] exp_sync;
    logic [31:0] exp_pend;
    logic        exp_irq;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h, want %h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic model_reset();
    samp.delete();
    m_stable   = '0;
    m_stable_q = '0;
    m_pending  = '0;
  endtask

  // Drive one cycle, advance the model by the stated rules, compare after the edge.
  task automatic step(input logic [31:0] in, input logic [31:0] clr);
    logic [31:0] s_new, ev, rise, fall, pend_new, h;
    int t;
    gpio_in_i = in;
    clr_i     = clr;
    t = DEB ? int'(deb_thresh_i) : 0;
    for (int i = 0; i < 32; i++) begin
      logic want, ok;
      want = ~m_stable[i];
      ok   = 1'b1;
      for (int j = 0; j <= t; j++) begin
        h = (samp.size() > j + 1) ? samp[j+1] : 32'h0;
        if (h[i] != want) ok = 1'b0;
      end
      s_new[i] = ok ? want : m_stable[i];
    end
    rise = m_stable & ~m_stable_q;
    fall = ~m_stable & m_stable_q;
    for (int i = 0; i < 32; i++) begin
      case (irq_type_i[2*i +: 2])
        2'b00:   ev[i] = fall[i];
        2'b01:   ev[i] = rise[i];
        2'b10:   ev[i] = rise[i] | fall[i];
        default: ev[i] = m_stable[i];
      endcase
    end
    pend_new = (m_pending & ~clr) | (ev & gpio_en_i);
    samp.push_front(in);
    if (samp.size() > 300) void'(samp.pop_back());
    @(posedge clk_i);
    #1;
    m_stable_q = m_stable;
    m_stable   = s_new;
    m_pending  = pend_new;
    chk("model_sync", gpio_sync_o, m_stable);
    chk("model_pending", pending_o, m_pending);
    chk("model_irq", {31'b0, irq_o}, {31'b0, |m_pending});
  endtask

  task automatic do_reset(input logic [7:0] thr);
    rst_ni = 1'b0;
    model_reset();
    cin = '0;
    gpio_in_i = '0;
    clr_i = '0;
    deb_thresh_i = thr;
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  initial begin
    logic saw;
    rst_ni = 1'b0;
    gpio_in_i = '0;
    gpio_en_i = '0;
    irq_type_i = '0;
    deb_thresh_i = '0;
    clr_i = '0;
    cin = '0;
    model_reset();
    repeat (3) @(posedge clk_i);
    #1;
    chk("reset_sync", gpio_sync_o, 32'h0);
    chk("reset_pending", pending_o, 32'h0);
    chk("reset_irq", {31'b0, irq_o}, 32'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Pin 3 rising, enabled, threshold 0.
    tbl[0]  = '{32'h0, 32'h0, 32'h0, 32'h0, 1'b0};
    tbl[1]  = '{32'h8, 32'h0, 32'h0, 32'h0, 1'b0};
    tbl[2]  = '{32'h8, 32'h0, 32'h0, 32'h0, 1'b0};
    tbl[3]  = '{32'h8, 32'h0, 32'h8, 32'h0, 1'b0};
    tbl[4]  = '{32'h8, 32'h0, 32'h8, 32'h8, 1'b1};
    tbl[5]  = '{32'h8, 32'h0, 32'h8, 32'h8, 1'b1};
    tbl[6]  = '{32'h8, 32'h8, 32'h8, 32'h0, 1'b0};
    tbl[7]  = '{32'h0, 32'h0, 32'h8, 32'h0, 1'b0};
    tbl[8]  = '{32'h0, 32'h0, 32'h8, 32'h0, 1'b0};
    tbl[9]  = '{32'h0, 32'h0, 32'h0, 32'h0, 1'b0};
    tbl[10] = '{32'h0, 32'h0, 32'h0, 32'h0, 1'b0};
    irq_type_i = 64'h5555_5555_5555_5555;
    gpio_en_i  = 32'h8;
    for (int r = 0; r < 11; r++) begin
      step(tbl[r].in, tbl[r].clr);
      chk($sformatf("tbl%0d_sync", r), gpio_sync_o, tbl[r].exp_sync);
      chk($sformatf("tbl%0d_pending", r), pending_o, tbl[r].exp_pend);
      chk($sformatf("tbl%0d_irq", r), {31'b0, irq_o}, {31'b0, tbl[r].exp_irq});
    end

    // Debounce: threshold 4, pin 0 both edges.
    deb_thresh_i = 8'd4;
    irq_type_i[1:0] = 2'b10;
    gpio_en_i = 32'h1;
    saw = 1'b0;
    cin[0] = 1'b1;
    repeat (4) begin step(cin, 32'h0); saw |= gpio_sync_o[0]; end
    cin[0] = 1'b0;
    repeat (12) begin step(cin, 32'h0); saw |= gpio_sync_o[0]; end
    chk("deb4_sync_seen", {31'b0, saw}, {31'b0, ~DEB});
    chk("deb4_pending", {31'b0, pending_o[0]}, {31'b0, ~DEB});
    step(cin, 32'h1);
    saw = 1'b0;
    cin[0] = 1'b1;
    repeat (5) begin step(cin, 32'h0); saw |= gpio_sync_o[0]; end
    cin[0] = 1'b0;
    repeat (12) begin step(cin, 32'h0); saw |= gpio_sync_o[0]; end
    chk("deb5_sync_seen", {31'b0, saw}, 32'h1);
    chk("deb5_sync_final", {31'b0, gpio_sync_o[0]}, 32'h0);
    chk("deb5_pending", {31'b0, pending_o[0]}, 32'h1);
    deb_thresh_i = 8'd0;
    gpio_en_i = '0;
    step(cin, 32'hFFFF_FFFF);

    // Pin 7 level-high: clear ineffective while high.
    irq_type_i[15:14] = 2'b11;
    gpio_en_i = 32'h80;
    cin[7] = 1'b1;
    repeat (5) step(cin, 32'h0);
    chk("lvl_pending_set", {31'b0, pending_o[7]}, 32'h1);
    step(cin, 32'h80);
    chk("lvl_clr_blocked", {31'b0, pending_o[7]}, 32'h1);
    cin[7] = 1'b0;
    repeat (5) step(cin, 32'h0);
    step(cin, 32'h80);
    chk("lvl_clr_pending", pending_o, 32'h0);
    chk("lvl_clr_irq", {31'b0, irq_o}, 32'h0);

    // Pin 5 falling: clear in the detect cycle loses to the set.
    irq_type_i[11:10] = 2'b00;
    gpio_en_i = 32'h20;
    cin[5] = 1'b1;
    repeat (5) step(cin, 32'h0);
    chk("fall_no_rise_evt", {31'b0, pending_o[5]}, 32'h0);
    cin[5] = 1'b0;
    repeat (3) step(cin, 32'h0);
    chk("fall_before_evt", {31'b0, pending_o[5]}, 32'h0);
    step(cin, 32'h20);
    chk("fall_set_wins", {31'b0, pending_o[5]}, 32'h1);

    // Pin 2: edge while disabled must not appear when enabled later.
    gpio_en_i = '0;
    irq_type_i[5:4] = 2'b01;
    step(cin, 32'hFFFF_FFFF);
    cin[2] = 1'b1;
    repeat (5) step(cin, 32'h0);
    gpio_en_i = 32'h4;
    repeat (5) step(cin, 32'h0);
    chk("dis_no_fake_edge", {31'b0, pending_o[2]}, 32'h0);

    // Reset mid-operation with all pending and counters mid-count.
    deb_thresh_i = 8'd4;
    irq_type_i = '1;
    gpio_en_i = '1;
    cin = '1;
    repeat (12) step(cin, 32'h0);
    chk("all_pending", pending_o, 32'hFFFF_FFFF);
    cin = '0;
    repeat (2) step(cin, 32'h0);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("midrst_sync", gpio_sync_o, 32'h0);
    chk("midrst_pending", pending_o, 32'h0);
    chk("midrst_irq", {31'b0, irq_o}, 32'h0);
    model_reset();
    gpio_in_i = '0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (10) step(cin, 32'h0);
    chk("post_rst_pending", pending_o, 32'h0);
    chk("post_rst_irq", {31'b0, irq_o}, 32'h0);

    // Randomized run.
    do_reset(8'($urandom_range(0, 3)));
    irq_type_i = {$urandom, $urandom};
    gpio_en_i = $urandom;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 31) == 0) gpio_en_i = $urandom;
      if ($urandom_range(0, 63) == 0) irq_type_i = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 0) cin ^= ($urandom & $urandom & $urandom);
      step(cin, $urandom & $urandom & $urandom & $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
